// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state type and flag indices shared by alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;
    localparam logic [7:0] OP_MUL = 8'h08;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative shift-add unsigned multiplier, one step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                // Final step: the accumulator holds the full product next cycle.
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign prod = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Parametrised ALU with flags, valid/ready handshake and an
//               iterative multi-cycle multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_result;
    logic [NUM_FLAGS-1:0]   r_flags;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_is_mul;
    logic                   w_mul_done;
    logic [2*WIDTH-1:0]     w_prod;

    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH:0]         w_shl;
    logic [WIDTH:0]         w_shr;
    logic [SHW-1:0]         w_shamt;
    logic [WIDTH-1:0]       w_res;
    logic                   w_c;
    logic                   w_v;
    logic                   w_err;
    logic [NUM_FLAGS-1:0]   w_alu_flags;
    logic [NUM_FLAGS-1:0]   w_mul_flags;

    // Gated by rst_n so the source sees no ready while reset is asserted.
    assign in_ready = rst_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept && w_is_mul),
        .a     (in1),
        .b     (in2),
        .done  (w_mul_done),
        .prod  (w_prod)
    );

    // Single-cycle datapath; the extra top bit of each shift holds the bit shifted out.
    always_comb begin
        w_sum   = {1'b0, in1} + {1'b0, in2};
        w_diff  = {1'b0, in1} - {1'b0, in2};
        w_shamt = in2[SHW-1:0];
        w_shl   = {1'b0, in1} << w_shamt;
        w_shr   = {in1, 1'b0} >> w_shamt;
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND: w_res = in1 & in2;
            OP_OR:  w_res = in1 | in2;
            OP_XOR: w_res = in1 ^ in2;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_MUL: w_res = '0;
            default: w_err = 1'b1;
        endcase

        w_alu_flags         = '0;
        w_alu_flags[FLAG_Z] = (w_res == '0);
        w_alu_flags[FLAG_N] = w_res[WIDTH-1];
        w_alu_flags[FLAG_C] = w_c;
        w_alu_flags[FLAG_V] = w_v;

        w_mul_flags         = '0;
        w_mul_flags[FLAG_Z] = (w_prod[WIDTH-1:0] == '0);
        w_mul_flags[FLAG_N] = w_prod[WIDTH-1];
        w_mul_flags[FLAG_C] = |w_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_is_mul) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)           w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output slot: loaded on completion, held under backpressure, freed on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else if (r_state == ST_MUL) begin
            if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_prod[WIDTH-1:0];
                r_flags     <= w_mul_flags;
                r_err       <= 1'b0;
            end
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= w_alu_flags;
            r_err       <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_flags[FLAG_Z];
    assign flag_n    = r_flags[FLAG_N];
    assign flag_c    = r_flags[FLAG_C];
    assign flag_v    = r_flags[FLAG_V];
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_z;
    logic       flag_n;
    logic       flag_c;
    logic       flag_v;
    logic       err;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one op, lets the next rising edge accept it, then drops in_valid.
    task automatic issue(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after a MUL accept until out_valid; flags any cycle with in_ready high meanwhile.
    task automatic wait_mul(output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && in_ready) rdy_seen = 1'b1;
        end
    endtask

    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    initial begin
        int   lat;
        logic rdy_seen;
        logic stale;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result",    result,    0);
        chk("rst_flags",     flags(),   0);
        chk("rst_err",       err,       0);
        chk("rst_in_ready",  in_ready,  0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", in_ready, 1);

        issue(8'h01, 8'h7F, 8'h01);
        chk("add_valid",  out_valid, 1);
        chk("add_result", result,    8'h80);
        chk("add_flags",  flags(),   4'b0101);
        chk("add_err",    err,       0);

        issue(8'h02, 8'h05, 8'h07);
        chk("sub_valid",  out_valid, 1);
        chk("sub_result", result,    8'hFE);
        chk("sub_flags",  flags(),   4'b0110);
        issue(8'h02, 8'h33, 8'h33);
        chk("subz_valid",  out_valid, 1);
        chk("subz_result", result,    8'h00);
        chk("subz_flags",  flags(),   4'b1000);
        @(posedge clk); #1;
        chk("drain_valid", out_valid, 0);

        issue(8'h06, 8'h81, 8'h09);
        chk("shl_result", result,  8'h02);
        chk("shl_flags",  flags(), 4'b0010);
        issue(8'h07, 8'h81, 8'h00);
        chk("shr0_result", result,  8'h81);
        chk("shr0_flags",  flags(), 4'b0100);
        issue(8'h05, 8'hA5, 8'hFF);
        chk("xor_result", result,  8'h5A);
        issue(8'h01, 8'hFF, 8'h01);
        chk("addc_result", result,  8'h00);
        chk("addc_flags",  flags(), 4'b1010);

        issue(8'h08, 8'h0F, 8'h11);
        chk("mul_ready_low", in_ready,  0);
        chk("mul_busy_valid", out_valid, 0);
        wait_mul(lat, rdy_seen);
        chk("mul_latency",  lat,      9);
        chk("mul_rdy_busy", rdy_seen, 0);
        chk("mul_result",   result,   8'hFF);
        chk("mul_flags",    flags(),  4'b0100);
        chk("mul_err",      err,      0);

        issue(8'h08, 8'h10, 8'h10);
        wait_mul(lat, rdy_seen);
        chk("mul2_latency", lat,     9);
        chk("mul2_result",  result,  8'h00);
        chk("mul2_flags",   flags(), 4'b1010);
        @(posedge clk); #1;
        chk("mul2_drain", out_valid, 0);

        out_ready = 1'b0;
        issue(8'h2A, 8'h05, 8'h06);
        chk("ill_valid",  out_valid, 1);
        chk("ill_result", result,    8'h00);
        chk("ill_flags",  flags(),   4'b1000);
        chk("ill_err",    err,       1);
        chk("ill_ready",  in_ready,  0);
        op = 8'h01; in1 = 8'h01; in2 = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_result", result,    8'h00);
            chk("hold_err",    err,       1);
            chk("hold_valid",  out_valid, 1);
            chk("hold_ready",  in_ready,  0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("swap_valid",  out_valid, 1);
        chk("swap_result", result,    8'h02);
        chk("swap_err",    err,       0);
        @(posedge clk); #1;
        chk("swap_drain", out_valid, 0);
        chk("idle_ready", in_ready,  1);

        issue(8'h08, 8'h0F, 8'h11);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid",  out_valid, 0);
        chk("abort_result", result,    0);
        chk("abort_ready",  in_ready,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("abort_no_stale", stale, 0);
        issue(8'h01, 8'h10, 8'h20);
        chk("post_valid",  out_valid, 1);
        chk("post_result", result,    8'h30);
        chk("post_flags",  flags(),   4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the 8-bit ADD/SUB ALU.
- Generalised data width; richer op set; status flags; valid/ready handshake on input and output; iterative multi-cycle multiply.
- Sits between the control unit and the register file: control unit issues an op plus operands and collects result and flags when ready.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  op/in1/in2 valid.
- in_ready  output  1  block can accept a new op this cycle.
- op  input  8  operation code (encoding below).
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B / shift amount.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  registered result.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[WIDTH-1].
- flag_c  output  1  carry/borrow/shift-out/mul-overflow (see below).
- flag_v  output  1  signed overflow (ADD/SUB only, else 0).
- err  output  1  illegal opcode on this result.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low. In reset: state=IDLE, out_valid=0, result=0, all flags=0, err=0, in_ready=0. in_ready rises combinationally once rst_n is high and conditions hold.
- Opcodes:
  - 8'h01 ADD, 8'h02 SUB, 8'h03 AND, 8'h04 OR, 8'h05 XOR.
  - 8'h06 SHL, 8'h07 SHR (logical).
  - 8'h08 MUL (low WIDTH bits of the unsigned product).
  - Any other value is illegal.
- Accept: occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- FSM states: IDLE, MUL, OUT-slot handled by out_valid.
  - IDLE, accept of a non-MUL op: result, flags and err registered at that edge; out_valid=1 on the next cycle. Latency is 1 cycle; throughput is 1 op/cycle when out_ready is held high.
  - IDLE, accept of MUL: latch operands, state=MUL, counter=0.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the last step, result is registered, out_valid=1 and state=IDLE. MUL latency is WIDTH+1 cycles from accept to out_valid. in_ready=0 throughout MUL.
- Output hold: while out_valid && !out_ready, result, flags and err are held stable. out_valid drops the cycle after the out_ready handshake unless a new op is accepted in the same cycle, in which case out_valid stays 1 with the new data.
- Arithmetic:
  - ADD: flag_c = carry out of bit WIDTH-1. flag_v = (in1[msb]==in2[msb]) && (res[msb]!=in1[msb]).
  - SUB: result = in1-in2 mod 2^WIDTH. flag_c = borrow (in1<in2 unsigned). flag_v = (in1[msb]!=in2[msb]) && (res[msb]!=in1[msb]).
  - Logic ops: flag_c=0, flag_v=0.
  - SHL/SHR: amount = in2[SHW-1:0]; upper bits of in2 are ignored. flag_c = last bit shifted out. An amount of 0 gives result=in1, flag_c=0.
  - MUL: flag_c = 1 if any bit of the upper WIDTH of the full product is nonzero.
- Illegal op: result=0, flag_z=1, other flags 0, err=1. Latency is 1 cycle. The block never stalls on an illegal op.
- Reset mid-MUL: the operation is aborted and no result is produced; all outputs go to reset values immediately.
- in_valid while in_ready=0: ignored; the source must hold in_valid and operands until the handshake completes.

Decomposition:
- alu_pkg:
  - opcode localparams OP_ADD..OP_MUL (8-bit);
  - state enum (IDLE, MUL);
  - flag index constants.
- One sub-module, alu_mul_seq: iterative shift-add multiplier.
  - Interface: start, a, b in; done, prod[2*WIDTH-1:0] out.
  - Parametrised by WIDTH; same clk/rst_n.
- Top-level alu_seq keeps the handshake, the single-cycle datapath and flag generation.

Test Plan:
- Reset and ADD: reset, then WIDTH=8, ADD 8'h7F+8'h01 with out_ready=1 -> next cycle result=8'h80, flag_n=1, flag_v=1, flag_c=0, flag_z=0, err=0.
- SUB borrow and zero:
  - SUB 8'h05-8'h07 -> result=8'hFE, flag_c=1, flag_n=1.
  - Then SUB 8'h33-8'h33 back-to-back -> result=8'h00, flag_z=1; out_valid stays high on both cycles.
- Shifts:
  - SHL 8'h81 by in2=8'h09 (amount 1) -> result=8'h02, flag_c=1.
  - SHR 8'h81 by 0 -> result=8'h81, flag_c=0.
- MUL:
  - MUL 8'h0F*8'h11 -> out_valid exactly 9 cycles after accept, result=8'hFF, flag_c=0, in_ready=0 during MUL.
  - MUL 8'h10*8'h10 -> result=8'h00, flag_c=1, flag_z=1.
- Backpressure and illegal op:
  - op=8'h2A with out_ready=0 for 4 cycles -> result=0, err=1, outputs held stable, in_ready=0.
  - Release out_ready -> handshake, then in_ready=1.
- Reset mid-MUL: assert rst_n=0 at cycle 3 of MUL -> out_valid=0, result=0, no stale result after release; a new ADD completes normally.
